mem_if_protocol_monitor: RTL and testbench

//  Synthesisable, parametrised req/gnt memory-interface protocol monitor for NCH ports.

---
 rtl/mem_if_mon_pkg.sv | 14 +
 rtl/mem_if_protocol_monitor_if.sv | 20 ++
 rtl/mem_if_mon_chan.sv | 103 ++++++++++
 rtl/mem_if_protocol_monitor.sv | 122 ++++++++++++
 tb/tb_mem_if_protocol_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_mon_pkg.sv
// Shared types for the req/gnt memory-interface protocol monitor.
package mem_if_mon_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    HOLD = 2'd1,
    GNT  = 2'd2,
    TMO  = 2'd3
  } viol_type_t;

  localparam int unsigned VCNT_W = 16;
  localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

endpackage

// File: rtl/mem_if_protocol_monitor_if.sv
// Bundled req/gnt memory port signals for NCH channels; the monitor taps them via the monitor modport.
interface mem_if_protocol_monitor_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NCH-1:0]        mem_req;
  logic [NCH*ADDR_W-1:0] mem_addr;
  logic [NCH-1:0]        mem_wen;
  logic [NCH*STRB_W-1:0] mem_strb;
  logic [NCH*DATA_W-1:0] mem_wdata;
  logic [NCH-1:0]        mem_gnt;

  modport master  (output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata, input mem_gnt);
  modport slave   (input mem_req, mem_addr, mem_wen, mem_strb, mem_wdata, output mem_gnt);
  modport monitor (input mem_req, mem_addr, mem_wen, mem_strb, mem_wdata, mem_gnt);

endinterface

// File: rtl/mem_if_mon_chan.sv
// One monitored channel: stalled-request capture, hold/grant checks, stall counter (MEM_IF_MON_TIMEOUT_EN).
// Passive tap, never backpressures; new-violation outputs are combinational on the current cycle.
module mem_if_mon_chan #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter bit          STRICT_WD = 1'b0
`ifdef MEM_IF_MON_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
  input  logic                f_clk,
  input  logic                g_resetn,
  input  logic                arm,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                gnt,
  output logic                hold_new,
  output logic                gnt_new,
  output logic                tmo_new
);

  logic                pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                stall;
  logic                data_chk;

  assign stall = req && !gnt;

  // Recapture on every stalled cycle so a changed field is reported once, not every cycle.
  always_comb begin
    pending_d = stall;
    addr_d    = addr_q;
    wen_d     = wen_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    if (stall) begin
      addr_d  = addr;
      wen_d   = wen;
      strb_d  = strb;
      wdata_d = wdata;
    end
  end

  always_comb begin
    data_chk = STRICT_WD || wen_q;
    hold_new = arm && pending_q &&
               (!req || (addr != addr_q) || (wen != wen_q) ||
                (data_chk && ((strb != strb_q) || (wdata != wdata_q))));
    gnt_new  = arm && gnt && !req;
  end

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef MEM_IF_MON_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counter holds the number of earlier consecutive stall cycles; saturation stops refiring.
  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + 1'b1;
    end
  end

  assign tmo_new = arm && stall && (stall_cnt_q == CNT_FIRE);

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign tmo_new = 1'b0;
`endif

endmodule

// File: rtl/mem_if_protocol_monitor.sv
// Req/gnt protocol monitor for NCH ports: sticky hold/grant/timeout flags, first record, violation count.
// Passive tap, never backpressures; flags appear one cycle after the offending cycle. Timeouts need MEM_IF_MON_TIMEOUT_EN.
module mem_if_protocol_monitor
  import mem_if_mon_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter bit          STRICT_WD   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     f_clk,
  input  logic                     g_resetn,
  mem_if_protocol_monitor_if.monitor mem_bus,
  input  logic                     mon_clr,
  output logic [NCH-1:0]           viol_hold,
  output logic [NCH-1:0]           viol_gnt,
  output logic [NCH-1:0]           viol_tmo,
  output logic                     viol_any,
  output logic [CH_W-1:0]          first_ch,
  output logic [1:0]               first_type,
  output logic [VCNT_W-1:0]        viol_cnt
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  logic              arm_q, arm_d;
  logic [NCH-1:0]    hold_new, gnt_new, tmo_new;
  logic [NCH-1:0]    viol_hold_q, viol_hold_d;
  logic [NCH-1:0]    viol_gnt_q, viol_gnt_d;
  logic [NCH-1:0]    viol_tmo_q, viol_tmo_d;
  logic [CH_W-1:0]   first_ch_q, first_ch_d;
  viol_type_t        first_type_q, first_type_d;
  logic [VCNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic              new_any;
  logic              rec_open;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    mem_if_mon_chan #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .STRICT_WD(STRICT_WD)
`ifdef MEM_IF_MON_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_chan (
      .f_clk   (f_clk),
      .g_resetn(g_resetn),
      .arm     (arm_q),
      .req     (mem_bus.mem_req[c]),
      .addr    (mem_bus.mem_addr[c*ADDR_W +: ADDR_W]),
      .wen     (mem_bus.mem_wen[c]),
      .strb    (mem_bus.mem_strb[c*STRB_W +: STRB_W]),
      .wdata   (mem_bus.mem_wdata[c*DATA_W +: DATA_W]),
      .gnt     (mem_bus.mem_gnt[c]),
      .hold_new(hold_new[c]),
      .gnt_new (gnt_new[c]),
      .tmo_new (tmo_new[c])
    );
  end

  assign viol_any = |{viol_hold_q, viol_gnt_q, viol_tmo_q};

  // Clear is applied first so a violation in the clearing cycle lands in the fresh record.
  always_comb begin
    arm_d        = 1'b1;
    viol_hold_d  = (mon_clr ? '0 : viol_hold_q) | hold_new;
    viol_gnt_d   = (mon_clr ? '0 : viol_gnt_q) | gnt_new;
    viol_tmo_d   = (mon_clr ? '0 : viol_tmo_q) | tmo_new;
    first_ch_d   = mon_clr ? '0 : first_ch_q;
    first_type_d = mon_clr ? NONE : first_type_q;
    viol_cnt_d   = mon_clr ? '0 : viol_cnt_q;
    new_any      = |{hold_new, gnt_new, tmo_new};
    rec_open     = mon_clr || !viol_any;
    if (rec_open && new_any) begin
      // Walk downwards so the lowest violating channel is the last writer.
      for (int c = int'(NCH) - 1; c >= 0; c--) begin
        if (hold_new[c] || gnt_new[c] || tmo_new[c]) begin
          first_ch_d   = CH_W'(c);
          first_type_d = hold_new[c] ? HOLD : (gnt_new[c] ? GNT : TMO);
        end
      end
    end
    if (new_any && (viol_cnt_d != VCNT_MAX)) begin
      viol_cnt_d = viol_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      arm_q        <= 1'b0;
      viol_hold_q  <= '0;
      viol_gnt_q   <= '0;
      viol_tmo_q   <= '0;
      first_ch_q   <= '0;
      first_type_q <= NONE;
      viol_cnt_q   <= '0;
    end else begin
      arm_q        <= arm_d;
      viol_hold_q  <= viol_hold_d;
      viol_gnt_q   <= viol_gnt_d;
      viol_tmo_q   <= viol_tmo_d;
      first_ch_q   <= first_ch_d;
      first_type_q <= first_type_d;
      viol_cnt_q   <= viol_cnt_d;
    end
  end

  assign viol_hold  = viol_hold_q;
  assign viol_gnt   = viol_gnt_q;
  assign viol_tmo   = viol_tmo_q;
  assign first_ch   = first_ch_q;
  assign first_type = first_type_q;
  assign viol_cnt   = viol_cnt_q;

endmodule

// File: tb/tb_mem_if_protocol_monitor.sv
// Bench for mem_if_protocol_monitor: two monitors (STRICT_WD 0 and 1) on one bus, directed plus random stimulus.
module tb_mem_if_protocol_monitor;

  localparam int NCH = 2;
  localparam int TMO = 4;
`ifdef MEM_IF_MON_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic f_clk;
  logic g_resetn;
  logic mon_clr;

  mem_if_protocol_monitor_if #(.NCH(NCH), .ADDR_W(32), .DATA_W(32)) mif ();

  logic [1:0]  o_hold[2];
  logic [1:0]  o_gnt[2];
  logic [1:0]  o_tmo[2];
  logic        o_any[2];
  logic [0:0]  o_fch[2];
  logic [1:0]  o_ftype[2];
  logic [15:0] o_cnt[2];

  for (genvar s = 0; s < 2; s++) begin : g_dut
    mem_if_protocol_monitor #(
      .NCH        (NCH),
      .ADDR_W     (32),
      .DATA_W     (32),
      .STRICT_WD  (s == 1),
      .TIMEOUT_CYC(TMO)
    ) u_dut (
      .f_clk     (f_clk),
      .g_resetn  (g_resetn),
      .mem_bus   (mif),
      .mon_clr   (mon_clr),
      .viol_hold (o_hold[s]),
      .viol_gnt  (o_gnt[s]),
      .viol_tmo  (o_tmo[s]),
      .viol_any  (o_any[s]),
      .first_ch  (o_fch[s]),
      .first_type(o_ftype[s]),
      .viol_cnt  (o_cnt[s])
    );
  end

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: per-variant observable state, plus the last stalled request per channel.
  bit [1:0] m_hold[2], m_gnt[2], m_tmo[2];
  int       m_fch[2], m_ftype[2], m_cnt[2];
  bit       held_v[NCH];
  bit [31:0] held_addr[NCH], held_wdata[NCH];
  bit        held_wen[NCH];
  bit [3:0]  held_strb[NCH];
  int        run[NCH];
  bit        armed;

  task automatic model_step();
    bit [1:0] nh[2];
    bit [1:0] ng;
    bit [1:0] nt;
    bit       found;
    if (!g_resetn) begin
      armed = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        held_v[c] = 1'b0; run[c] = 0;
      end
      for (int s = 0; s < 2; s++) begin
        m_hold[s] = '0; m_gnt[s] = '0; m_tmo[s] = '0;
        m_fch[s] = 0; m_ftype[s] = 0; m_cnt[s] = 0;
      end
    end else begin
      ng = '0; nt = '0; nh[0] = '0; nh[1] = '0;
      for (int c = 0; c < NCH; c++) begin
        bit        rq, gn, wn, stalled, fld, dat;
        bit [31:0] a, d;
        bit [3:0]  st;
        rq = mif.mem_req[c]; gn = mif.mem_gnt[c]; wn = mif.mem_wen[c];
        a  = mif.mem_addr[c*32 +: 32]; d = mif.mem_wdata[c*32 +: 32];
        st = mif.mem_strb[c*4 +: 4];
        stalled = rq && !gn;
        fld = !rq || (a != held_addr[c]) || (wn != held_wen[c]);
        dat = (st != held_strb[c]) || (d != held_wdata[c]);
        for (int s = 0; s < 2; s++)
          nh[s][c] = armed && held_v[c] && (fld || ((held_wen[c] || s == 1) && dat));
        ng[c] = armed && gn && !rq;
        run[c] = stalled ? run[c] + 1 : 0;
        nt[c] = TMO_EN && armed && stalled && (run[c] == TMO);
        held_v[c] = stalled;
        if (stalled) begin
          held_addr[c] = a; held_wen[c] = wn; held_strb[c] = st; held_wdata[c] = d;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (mon_clr) begin
          m_hold[s] = '0; m_gnt[s] = '0; m_tmo[s] = '0;
          m_fch[s] = 0; m_ftype[s] = 0; m_cnt[s] = 0;
        end
        if ((nh[s] | ng | nt) != 0) begin
          if ((m_hold[s] | m_gnt[s] | m_tmo[s]) == 0) begin
            found = 1'b0;
            for (int c = 0; c < NCH; c++) begin
              if (!found && (nh[s][c] || ng[c] || nt[c])) begin
                found = 1'b1;
                m_fch[s] = c;
                m_ftype[s] = nh[s][c] ? 1 : (ng[c] ? 2 : 3);
              end
            end
          end
          if (m_cnt[s] < 65535) m_cnt[s]++;
        end
        m_hold[s] |= nh[s]; m_gnt[s] |= ng; m_tmo[s] |= nt;
      end
      armed = 1'b1;
    end
  endtask

  always @(posedge f_clk) model_step();

  always @(negedge f_clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("d%0d viol_hold", s), 32'(o_hold[s]), 32'(m_hold[s]));
        chk($sformatf("d%0d viol_gnt", s), 32'(o_gnt[s]), 32'(m_gnt[s]));
        chk($sformatf("d%0d viol_tmo", s), 32'(o_tmo[s]), 32'(m_tmo[s]));
        chk($sformatf("d%0d viol_any", s), 32'(o_any[s]), 32'((m_hold[s] | m_gnt[s] | m_tmo[s]) != 0));
        chk($sformatf("d%0d first_ch", s), 32'(o_fch[s]), 32'(m_fch[s]));
        chk($sformatf("d%0d first_type", s), 32'(o_ftype[s]), 32'(m_ftype[s]));
        chk($sformatf("d%0d viol_cnt", s), 32'(o_cnt[s]), 32'(m_cnt[s]));
      end
    end
  end

  task automatic drive(input int c, input bit rq, input logic [31:0] a, input bit wn,
                       input logic [3:0] st, input logic [31:0] d, input bit gn);
    mif.mem_req[c] = rq;
    mif.mem_addr[c*32 +: 32] = a;
    mif.mem_wen[c] = wn;
    mif.mem_strb[c*4 +: 4] = st;
    mif.mem_wdata[c*32 +: 32] = d;
    mif.mem_gnt[c] = gn;
  endtask

  task automatic idle();
    for (int c = 0; c < NCH; c++) drive(c, 0, 0, 0, 0, 0, 0);
    mon_clr = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge f_clk);
      #1;
    end
  endtask

  task automatic clear_all();
    idle();
    mon_clr = 1'b1;
    cyc(1);
    mon_clr = 1'b0;
  endtask

  task automatic rand_cycle();
    for (int c = 0; c < NCH; c++) begin
      int          r;
      bit          rq, gn, wn;
      logic [31:0] a, d;
      logic [3:0]  st;
      r  = $urandom_range(0, 99);
      rq = mif.mem_req[c]; gn = mif.mem_gnt[c]; wn = mif.mem_wen[c];
      a  = mif.mem_addr[c*32 +: 32]; d = mif.mem_wdata[c*32 +: 32];
      st = mif.mem_strb[c*4 +: 4];
      if (mif.mem_req[c] && !mif.mem_gnt[c] && r < 92) begin
        if (r >= 72) begin
          case ($urandom_range(0, 4))
            0: a  = a ^ 32'h8;
            1: wn = ~wn;
            2: st = st ^ 4'h1;
            3: d  = d ^ 32'h1;
            default: rq = 1'b0;
          endcase
        end
        gn = ($urandom_range(0, 3) == 0);
      end else begin
        rq = ($urandom_range(0, 2) != 0);
        a  = 32'($urandom_range(0, 3)) << 3;
        wn = 1'($urandom_range(0, 1));
        st = 4'($urandom_range(0, 15));
        d  = 32'($urandom_range(0, 3));
        gn = ($urandom_range(0, 2) == 0);
      end
      drive(c, rq, a, wn, st, d, gn);
    end
    mon_clr  = ($urandom_range(0, 39) == 0);
    g_resetn = ($urandom_range(0, 299) != 0);
  endtask

  initial begin
    g_resetn = 1'b0;
    idle();
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("rst viol_any", 32'(o_any[0]), 0);
    chk("rst viol_cnt", 32'(o_cnt[0]), 0);

    // Grant without request in the first post-reset cycle must not be flagged.
    g_resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc(1);
    idle();
    chk("arm gate", 32'(o_any[0]), 0);
    cyc(1);

    // Clean stall of three cycles then grant.
    drive(0, 1, 32'h100, 1, 4'hF, 32'hDEAD, 0);
    cyc(3);
    drive(0, 1, 32'h100, 1, 4'hF, 32'hDEAD, 1);
    cyc(1);
    idle();
    cyc(1);
    chk("clean viol_any", 32'(o_any[0]), 0);
    chk("clean viol_cnt", 32'(o_cnt[0]), 0);

    // Address change mid-stall.
    drive(0, 1, 32'h1000, 0, 0, 0, 0);
    cyc(1);
    drive(0, 1, 32'h1008, 0, 0, 0, 0);
    cyc(1);
    chk("addr viol_hold", 32'(o_hold[0]), 32'h1);
    chk("addr first_ch", 32'(o_fch[0]), 0);
    chk("addr first_type", 32'(o_ftype[0]), 1);
    chk("addr viol_cnt", 32'(o_cnt[0]), 1);
    drive(0, 1, 32'h1008, 0, 0, 0, 1);
    cyc(1);
    idle();
    cyc(1);
    chk("addr once viol_cnt", 32'(o_cnt[0]), 1);
    clear_all();
    chk("clr viol_any", 32'(o_any[0]), 0);
    chk("clr viol_cnt", 32'(o_cnt[0]), 0);

    // Write data change with wen=0: only the strict monitor flags it.
    drive(1, 1, 32'h2000, 0, 0, 32'hAAAA, 0);
    cyc(1);
    drive(1, 1, 32'h2000, 0, 0, 32'h5555, 0);
    cyc(1);
    chk("wd lax viol_hold", 32'(o_hold[0]), 0);
    chk("wd strict viol_hold", 32'(o_hold[1]), 32'h2);
    drive(1, 1, 32'h2000, 0, 0, 32'h5555, 1);
    cyc(1);
    clear_all();

    // Same cycle: ch0 drops req mid-stall, ch1 grant without request.
    drive(0, 1, 32'h3000, 1, 4'hF, 32'h1, 0);
    cyc(1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    cyc(1);
    chk("prio first_ch", 32'(o_fch[0]), 0);
    chk("prio first_type", 32'(o_ftype[0]), 1);
    chk("prio viol_cnt", 32'(o_cnt[0]), 1);
    chk("prio viol_gnt", 32'(o_gnt[0]), 32'h2);
    clear_all();

    // Stall ch1 for TIMEOUT cycles.
    drive(1, 1, 32'h4000, 0, 0, 0, 0);
    cyc(3);
    chk("tmo early", 32'(o_tmo[0]), 0);
    cyc(1);
    chk("tmo fire", 32'(o_tmo[0]), TMO_EN ? 32'h2 : 32'h0);
    chk("tmo first_type", 32'(o_ftype[0]), TMO_EN ? 32'd3 : 32'd0);
    drive(1, 1, 32'h4000, 0, 0, 0, 1);
    cyc(1);
    clear_all();

    // Clear in the same cycle as a new ch0 grant-without-request.
    drive(1, 0, 0, 0, 0, 0, 1);
    cyc(1);
    chk("pre-clr first_ch", 32'(o_fch[0]), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    mon_clr = 1'b1;
    cyc(1);
    mon_clr = 1'b0;
    idle();
    chk("clr+new viol_gnt", 32'(o_gnt[0]), 32'h1);
    chk("clr+new first_ch", 32'(o_fch[0]), 0);
    chk("clr+new first_type", 32'(o_ftype[0]), 2);
    chk("clr+new viol_cnt", 32'(o_cnt[0]), 1);
    cyc(1);
    clear_all();

    // Reset in the middle of a stall drops the pending transaction.
    drive(0, 1, 32'h5000, 0, 0, 0, 0);
    cyc(2);
    g_resetn = 1'b0;
    drive(0, 1, 32'h5008, 0, 0, 0, 0);
    cyc(1);
    g_resetn = 1'b1;
    idle();
    cyc(3);
    chk("rst stall viol_hold", 32'(o_hold[0]), 0);
    chk("rst stall viol_any", 32'(o_any[1]), 0);

    repeat (4000) begin
      rand_cycle();
      cyc(1);
    end
    g_resetn = 1'b1;
    idle();
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
